algo_mrpnwp_wr_arb: RTL and testbench
=====================================

# algo_mrpnwp_wr_arb

Round-robin write scheduler that shares the NUMWRPT virtual write ports of the multi-read/multi-write 1R1W-based memory core among NUMREQ independent requesters. Each cycle it grants up to NUMWRPT pending requests, packs them onto consecutive write slots, and drives the core's `vwrite`/`vaddr`/`vdin` from registers. All grants are held off while the core deasserts `ready`.

## Interface
- WIDTH, 32, data width per write
- BITADDR, 13, address width
- NUMREQ, 8, number of requesters
- BITREQ, 3, clog2(NUMREQ)
- NUMWRPT, 3, core write ports; must satisfy NUMWRPT <= NUMREQ
- clk  input  1  clock; one clock domain
- rst  input  1  reset; asynchronous, active-high
- ready  input  1  core initialised and able to accept writes
- req_vld  input  NUMREQ  request pending, one bit per requester
- req_adr  input  NUMREQ*BITADDR  request address; requester i uses bits [i*BITADDR +: BITADDR]
- req_din  input  NUMREQ*WIDTH  request data; requester i uses bits [i*WIDTH +: WIDTH]
- req_gnt  output  NUMREQ  request accepted this cycle; combinational
- vwrite  output  NUMWRPT  registered write enable per slot, to the core
- vaddr  output  NUMWRPT*BITADDR  registered write address per slot
- vdin  output  NUMWRPT*WIDTH  registered write data per slot

## Operation
- Handshake: a requester holds `req_vld`/`req_adr`/`req_din` stable until it sees `req_gnt[i]`=1 in the same cycle. It may drop `req_vld` in the following cycle or present a new request.
- `req_gnt[i]` requires `req_vld[i]` and `ready`. With `ready`=0, `req_gnt`=0 and `vwrite` is 0 on the next edge.
- Selection: scan requesters in circular order starting at `ptr` (BITREQ bits). Grant the first up to NUMWRPT eligible requesters.
- Slot packing: the k-th granted requester in scan order is placed in slot k. Unused slots get `vwrite`=0; their `vaddr`/`vdin` hold their previous values.
- Pointer update: if at least one grant is issued, `ptr` becomes (last granted index + 1) mod NUMREQ. With no grant, `ptr` holds.
- Fairness: with no collisions, every continuously valid requester is granted within ceil(NUMREQ/NUMWRPT) ready cycles.
- Address collision (macro enabled only): a requester whose `req_adr` equals that of a requester already granted earlier in the same scan is skipped. The skip does not consume a slot. The skipped requester keeps its place and wins on a later cycle.

## Timing
- Reset values: `ptr`=0, `vwrite`=0, `vaddr`=0, `vdin`=0. `req_gnt`=0 while `rst` is high.
- A request granted in cycle N appears on `vwrite`/`vaddr`/`vdin` in cycle N+1 (registered, latency 1).
- `ready` falling in cycle N blocks grants in cycle N. Writes granted in cycle N-1 still issue in cycle N.
- Reset asserted mid-operation clears the output registers immediately. A grant pulsed in that cycle is lost, and the requester must retry.
- Wrap-around: the scan from `ptr`=NUMREQ-1 continues at index 0. The pointer arithmetic is mod NUMREQ, including non-power-of-2 NUMREQ.

## Configuration
- `MRPNWP_ARB_ADDR_CHK_EN`, defined: enables the same-cycle address-collision check above. Two writes to one address never issue in the same cycle.
- Not defined: no address compare is performed, and upstream guarantees distinct addresses. Equal-address requests may be granted together, and the result in the core is undefined.

## Structure
- Package `algo_mrpnwp_arb_pkg` holds:
  - the slot-index function
  - a `clog2` constant function
  - the pointer-wrap helper
- Sub-module `algo_mrpnwp_rr_pick` is a rotated priority picker. It takes an eligibility vector and `ptr`, and returns a one-hot pick and its index. The arbiter instantiates NUMWRPT chained copies, each with previously picked requesters masked out.

## Test plan
All scenarios use NUMREQ=4 and NUMWRPT=2.
- **Reset:** assert `rst` mid-stream with `req_vld`=4'b1111. Response: `vwrite`=0 immediately and `req_gnt`=0. After release, the first grants go to requesters 0 and 1, in slots 0 and 1.
- **Round-robin rotation:** hold `req_vld`=4'b1111 with `ready`=1. Response: grants 4'b0011, 4'b1100, 4'b0011, and so on. Each set of writes appears one cycle after its grant.
- **Wrap and packing:** `ptr`=3 with `req_vld`=4'b1010. Response: requester 3 goes to slot 0, requester 1 to slot 1, and `ptr` becomes 2.
- **Ready stall:** drop `ready` for 3 cycles with all requesters valid. Response: no grants and `vwrite`=0 for those cycles (offset by the 1-cycle latency). `ptr` is unchanged, and grants resume from the same requester.
- **Collision (macro defined):** requesters 0 and 1 both address 0x1A5. Response: requester 0 is granted, requester 1 is skipped, and requester 2 takes slot 1. Requester 1 is granted in the next cycle.
- **Collision (macro undefined):** same stimulus. Response: requesters 0 and 1 are both granted, and both slots carry 0x1A5.

Source files
------------

// File: rtl/algo_mrpnwp_arb_pkg.sv
// Shared helpers for the multi-port write arbiter: index rotation, pointer wrap,
// slot bit offsets and a constant clog2.
package algo_mrpnwp_arb_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    // Position of the k-th requester visited by a scan that starts at base.
    function automatic int rot_idx(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

    // Successor of idx modulo n; works for non-power-of-2 n.
    function automatic int ptr_wrap(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    function automatic int slot_lsb(input int slot, input int w);
        return slot * w;
    endfunction

endpackage

// File: rtl/algo_mrpnwp_rr_pick.sv
// Rotated priority picker: first set bit of elig at or after ptr, circularly.
module algo_mrpnwp_rr_pick
    import algo_mrpnwp_arb_pkg::*;
#(
    parameter int NUMREQ = 8,
    parameter int BITREQ = clog2(NUMREQ)
) (
    input  logic [NUMREQ-1:0] elig,
    input  logic [BITREQ-1:0] ptr,
    output logic [NUMREQ-1:0] pick,
    output logic [BITREQ-1:0] idx,
    output logic              found
);

    int cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUMREQ; k++) begin
            cand = rot_idx(int'(ptr), k, NUMREQ);
            if (!found && elig[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = BITREQ'(cand);
            end
        end
    end

endmodule

// File: rtl/algo_mrpnwp_wr_arb.sv
// Round-robin scheduler packing up to NUMWRPT requesters onto the core write slots.
// Define MRPNWP_ARB_ADDR_CHK_EN to skip requesters colliding with an earlier grant's address.
module algo_mrpnwp_wr_arb
    import algo_mrpnwp_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMREQ  = 8,
    parameter int BITREQ  = 3,
    parameter int NUMWRPT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMREQ-1:0]          req_vld,
    input  logic [NUMREQ*BITADDR-1:0]  req_adr,
    input  logic [NUMREQ*WIDTH-1:0]    req_din,
    output logic [NUMREQ-1:0]          req_gnt,
    output logic [NUMWRPT-1:0]         vwrite,
    output logic [NUMWRPT*BITADDR-1:0] vaddr,
    output logic [NUMWRPT*WIDTH-1:0]   vdin
);

    logic [BITREQ-1:0]              ptr;
    logic [BITREQ-1:0]              ptr_nxt;
    logic [NUMREQ-1:0]              active;
    logic [NUMWRPT-1:0]             found_v;
    logic [NUMWRPT-1:0][BITREQ-1:0] idx_v;

    assign active  = req_vld & {NUMREQ{ready & ~rst}};
    assign req_gnt = g_stage[NUMWRPT-1].taken;

    // Each stage sees the cumulative picks (and clashes) of the stages before it,
    // so slot k receives the k-th eligible requester in scan order.
    for (genvar s = 0; s < NUMWRPT; s++) begin : g_stage
        logic [NUMREQ-1:0] taken_in;
        logic [NUMREQ-1:0] elig;
        logic [NUMREQ-1:0] pick;
        logic [NUMREQ-1:0] taken;
        logic [BITREQ-1:0] idx;
        logic              found;

        if (s == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_next
            assign taken_in = g_stage[s-1].taken;
        end

`ifdef MRPNWP_ARB_ADDR_CHK_EN
        logic [NUMREQ-1:0] clash_in;
        logic [NUMREQ-1:0] clash;
        logic [NUMREQ-1:0] match;

        if (s == 0) begin : g_clash_first
            assign clash_in = '0;
        end else begin : g_clash_next
            assign clash_in = g_stage[s-1].clash;
        end

        always_comb begin
            match = '0;
            for (int j = 0; j < NUMREQ; j++)
                match[j] = found &&
                    (req_adr[j*BITADDR +: BITADDR] == req_adr[int'(idx)*BITADDR +: BITADDR]);
        end

        assign clash = clash_in | match;
        assign elig  = active & ~taken_in & ~clash_in;
`else
        assign elig  = active & ~taken_in;
`endif

        algo_mrpnwp_rr_pick #(
            .NUMREQ(NUMREQ),
            .BITREQ(BITREQ)
        ) u_pick (
            .elig (elig),
            .ptr  (ptr),
            .pick (pick),
            .idx  (idx),
            .found(found)
        );

        assign taken      = taken_in | pick;
        assign found_v[s] = found;
        assign idx_v[s]   = idx;
    end

    // Found stages form a prefix, so the highest found stage holds the last grant.
    always_comb begin
        ptr_nxt = ptr;
        for (int s = 0; s < NUMWRPT; s++)
            if (found_v[s]) ptr_nxt = BITREQ'(ptr_wrap(int'(idx_v[s]), NUMREQ));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            vwrite <= '0;
            vaddr  <= '0;
            vdin   <= '0;
        end else begin
            ptr <= ptr_nxt;
            for (int s = 0; s < NUMWRPT; s++) begin
                vwrite[s] <= found_v[s];
                if (found_v[s]) begin
                    vaddr[slot_lsb(s, BITADDR) +: BITADDR] <= req_adr[int'(idx_v[s])*BITADDR +: BITADDR];
                    vdin[slot_lsb(s, WIDTH) +: WIDTH]      <= req_din[int'(idx_v[s])*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_algo_mrpnwp_wr_arb.sv
// Directed bench for the write arbiter at NUMREQ=4, NUMWRPT=2 with a one-deep scoreboard.
module tb_algo_mrpnwp_wr_arb;

    localparam int WIDTH   = 32;
    localparam int BITADDR = 13;
    localparam int NUMREQ  = 4;
    localparam int BITREQ  = 2;
    localparam int NUMWRPT = 2;

    typedef struct {
        logic [NUMWRPT-1:0]         vw;
        logic [NUMWRPT*BITADDR-1:0] va;
        logic [NUMWRPT*WIDTH-1:0]   vd;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       ready;
    logic [NUMREQ-1:0]          req_vld;
    logic [NUMREQ*BITADDR-1:0]  req_adr;
    logic [NUMREQ*WIDTH-1:0]    req_din;
    logic [NUMREQ-1:0]          req_gnt;
    logic [NUMWRPT-1:0]         vwrite;
    logic [NUMWRPT*BITADDR-1:0] vaddr;
    logic [NUMWRPT*WIDTH-1:0]   vdin;

    logic [BITADDR-1:0] adr_tb [NUMREQ];
    logic [WIDTH-1:0]   din_tb [NUMREQ];
    logic [BITADDR-1:0] hold_a [NUMWRPT];
    logic [WIDTH-1:0]   hold_d [NUMWRPT];
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_adr = '0;
        req_din = '0;
        for (int i = 0; i < NUMREQ; i++) begin
            req_adr[i*BITADDR +: BITADDR] = adr_tb[i];
            req_din[i*WIDTH +: WIDTH]     = din_tb[i];
        end
    end

    algo_mrpnwp_wr_arb #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .NUMREQ(NUMREQ), .BITREQ(BITREQ), .NUMWRPT(NUMWRPT)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready), .req_vld(req_vld), .req_adr(req_adr),
        .req_din(req_din), .req_gnt(req_gnt), .vwrite(vwrite), .vaddr(vaddr), .vdin(vdin)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_hold();
        for (int s = 0; s < NUMWRPT; s++) begin
            hold_a[s] = '0;
            hold_d[s] = '0;
        end
    endtask

    // Inputs are already driven; check the grant, then check the registered slots one edge later.
    task automatic cyc(input string tag, input logic [NUMREQ-1:0] g, input int s0, input int s1);
        exp_t e;
        #1;
        chk({tag, ".gnt"}, 64'(req_gnt), 64'(g));
        if (s0 >= 0) begin hold_a[0] = adr_tb[s0]; hold_d[0] = din_tb[s0]; end
        if (s1 >= 0) begin hold_a[1] = adr_tb[s1]; hold_d[1] = din_tb[s1]; end
        e.vw = {s1 >= 0, s0 >= 0};
        e.va = {hold_a[1], hold_a[0]};
        e.vd = {hold_d[1], hold_d[0]};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".vwrite"}, 64'(vwrite), 64'(e.vw));
        chk({tag, ".vaddr"},  64'(vaddr),  64'(e.va));
        chk({tag, ".vdin"},   64'(vdin),   64'(e.vd));
    endtask

    initial begin
        for (int i = 0; i < NUMREQ; i++) begin
            adr_tb[i] = 13'h100 + 13'(i);
            din_tb[i] = 32'hD000_0000 + 32'(i * 17);
        end
        clear_hold();
        rst     = 1'b1;
        ready   = 1'b1;
        req_vld = 4'b1111;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt", 64'(req_gnt), 64'h0);
        chk("rst.vwrite", 64'(vwrite), 64'h0);
        chk("rst.vaddr", 64'(vaddr), 64'h0);
        chk("rst.vdin", 64'(vdin), 64'h0);
        rst = 1'b0;

        // Round-robin rotation
        cyc("rr0", 4'b0011, 0, 1);
        cyc("rr1", 4'b1100, 2, 3);
        cyc("rr2", 4'b0011, 0, 1);

        // Mid-stream reset clears outputs at once; previous grant's write is lost
        rst = 1'b1;
        #1;
        chk("mrst.vwrite", 64'(vwrite), 64'h0);
        chk("mrst.vaddr", 64'(vaddr), 64'h0);
        chk("mrst.gnt", 64'(req_gnt), 64'h0);
        clear_hold();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst", 4'b0011, 0, 1);

        // Ready stall: pointer frozen at 2
        ready = 1'b0;
        cyc("stall0", 4'b0000, -1, -1);
        cyc("stall1", 4'b0000, -1, -1);
        cyc("stall2", 4'b0000, -1, -1);
        ready = 1'b1;
        cyc("resume", 4'b1100, 2, 3);

        // Move pointer to 3 with single grants (slot 1 must hold)
        req_vld = 4'b0001;
        cyc("single0", 4'b0001, 0, -1);
        req_vld = 4'b0100;
        cyc("single2", 4'b0100, 2, -1);

        // Wrap and packing from ptr=3
        req_vld = 4'b1010;
        cyc("wrap", 4'b1010, 3, 1);
        req_vld = 4'b1111;
        cyc("wrap_ptr", 4'b1100, 2, 3);

        // Collision from ptr=0
        adr_tb[0] = 13'h1A5;
        adr_tb[1] = 13'h1A5;
        req_vld   = 4'b1111;
`ifdef MRPNWP_ARB_ADDR_CHK_EN
        cyc("coll", 4'b0101, 0, 2);
        req_vld = 4'b1010;
        cyc("coll_next", 4'b1010, 3, 1);
`else
        cyc("coll", 4'b0011, 0, 1);
        req_vld = 4'b1100;
        cyc("coll_next", 4'b1100, 2, 3);
`endif

        // No requests: nothing granted, slots hold
        req_vld = 4'b0000;
        cyc("idle", 4'b0000, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
